// File: rtl/qspi_pkg.sv
// qspi_pkg: shared QSPI lane-mode type and lanes-per-sample helper
package qspi_pkg;
  typedef enum logic [1:0] {
    QSPI_SINGLE = 2'b00,
    QSPI_DUAL   = 2'b01,
    QSPI_QUAD   = 2'b10
  } qspi_mode_e;
  function automatic logic [2:0] qspi_lanes(qspi_mode_e m);
    return m == QSPI_SINGLE ? 3'd1 : m == QSPI_DUAL ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/qspi_rx_deser_if.sv
// qspi_rx_deser_if: valid/ready word stream from the deserialiser to the RX datapath
//   data  word, right-justified
//   valid word available
//   ready consumer accepts word when valid & ready
interface qspi_rx_deser_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/qspi_rx_fifo.sv
// qspi_rx_fifo: synchronous show-ahead FIFO with flush, fill count and full/empty flags
//   clk_i/rst_ni clock, async active-low reset; clr_i sync flush
//   push_i/wdata_i write (accepted when not full or popping same cycle)
//   pop_i read (ignored when empty); rdata_o head word, zero when empty
//   count_o fill level; full_o/empty_o status
module qspi_rx_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             wr, rd;
  assign empty_o = count_o == '0;
  assign full_o  = count_o == CW'(DEPTH);
  assign rd      = pop_i && !empty_o;
  assign wr      = push_i && (!full_o || rd);
  assign rdata_o = empty_o ? '0 : mem[rp];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp      <= '0;
      rp      <= '0;
      count_o <= '0;
    end else if (clr_i) begin
      wp      <= '0;
      rp      <= '0;
      count_o <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      count_o <= count_o + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk_i)
    if (wr) mem[wp] <= wdata_i;
endmodule

// File: rtl/qspi_rx_deser.sv
// qspi_rx_deser: QSPI 1/2/4-lane receive deserialiser feeding a show-ahead word FIFO
//   clk_i/rst_ni clock, async active-low reset; clr_i sync flush of word, FIFO and overflow
//   mode_i/msb_first_i/len_i lane mode, bit order, bytes-per-word-1 (latched at word start)
//   sample_i/last_i/qsd_i sampled IO lines, sample strobe, end-of-transfer flush
//   rx (master) FIFO head word with valid/ready
//   count_o FIFO fill; overflow_o sticky dropped-word flag; busy_o partial word in progress
module qspi_rx_deser
  import qspi_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = DATA_W > 8 ? $clog2(DATA_W / 8) : 1,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [1:0]       mode_i,
  input  logic             msb_first_i,
  input  logic [LW-1:0]    len_i,
  input  logic             sample_i,
  input  logic             last_i,
  input  logic [3:0]       qsd_i,
  qspi_rx_deser_if.master  rx,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             busy_o
);
  localparam int BW = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] sr_q, sr_base, sr_d, in_w, word;
  logic [BW-1:0]     cnt_q, cnt_d, k, tgt, sh;
  qspi_mode_e        mode_q, mode_e;
  logic [LW-1:0]     len_q, len_e;
  logic              msb_q, msb_e, start, push, pop, full, empty;
  assign start  = cnt_q == '0;
  assign busy_o = !start;
  // Live inputs apply only on the first sample of a word; afterwards the latched copy rules.
  always_comb begin
    mode_e  = start ? qspi_mode_e'(mode_i) : mode_q;
    len_e   = start ? len_i : len_q;
    msb_e   = start ? msb_first_i : msb_q;
    k       = BW'(qspi_lanes(mode_e));
    tgt     = BW'((int'(len_e) + 1) * 8);
    in_w    = mode_e == QSPI_SINGLE ? DATA_W'(qsd_i[1]) :
              mode_e == QSPI_DUAL   ? DATA_W'(qsd_i[1:0]) : DATA_W'(qsd_i);
    sr_base = start ? '0 : sr_q;
    sr_d    = !sample_i ? sr_q :
              msb_e ? (sr_base << k) | in_w : (sr_base >> k) | (in_w << (BW'(DATA_W) - k));
    cnt_d   = sample_i ? cnt_q + k : cnt_q;
    push    = (sample_i && cnt_d == tgt) || (last_i && cnt_d != '0);
    // LSB-first words fill from the top, so slide them down to bit 0 on push.
    sh      = msb_e ? '0 : BW'(DATA_W) - cnt_d;
    word    = sr_d >> sh;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      mode_q     <= QSPI_SINGLE;
      len_q      <= '0;
      msb_q      <= 1'b0;
      overflow_o <= 1'b0;
    end else if (clr_i) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      overflow_o <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= push ? '0 : cnt_d;
      if (sample_i && start) begin
        mode_q <= mode_e;
        len_q  <= len_e;
        msb_q  <= msb_e;
      end
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  assign pop      = rx.valid && rx.ready;
  assign rx.valid = !empty;
  qspi_rx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .push_i  (push),
    .wdata_i (word),
    .pop_i   (pop),
    .rdata_o (rx.data),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule
